prog_counter: RTL and testbench
===============================

# prog_counter

Parametrised, programmable successor to the free-running 32-bit counter. It adds a configurable width, a programmable terminal value, up, down and up/down (triangle) modes, free-run or one-shot operation, a clock prescaler, synchronous load, and a terminal-count pulse with a saturating event count. It serves as the general timer/period source for the datapath and replaces single-purpose counters.

## Interface
- WIDTH, 32: counter width, minimum 2.
- PRESCALE_W, 16: prescaler width.
- EVT_W, 16: width of wrap_count.
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  pulse; loads the mode start value and enters RUN.
- stop  in  1  pulse; returns to IDLE and holds counter.
- enable  in  1  gates prescaler and counting while in RUN.
- mode  in  2  counter_mode_t: MODE_UP=0, MODE_DOWN=1, MODE_UPDOWN=2; 3 is treated as MODE_UP.
- one_shot  in  1  1: stop at first terminal; 0: free-run.
- limit  in  WIDTH  terminal value; count range is 0..limit.
- prescale  in  PRESCALE_W  one step every prescale+1 enabled RUN cycles.
- load  in  1  synchronous load of load_value.
- load_value  in  WIDTH  load data; values above limit are clamped to limit.
- counter  out  WIDTH  current count (registered).
- dir  out  1  0 = counting up, 1 = counting down.
- tc  out  1  one-cycle terminal-count pulse (registered).
- done  out  1  high in DONE.
- busy  out  1  high in RUN.
- wrap_count  out  EVT_W  saturating count of tc pulses.

## Operation
- FSM states: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: counter=0, dir=0, tc=0, done=0, busy=0, wrap_count=0, prescaler=0.
- Transitions:
  - IDLE/DONE -> RUN on start.
  - RUN -> IDLE on stop.
  - RUN -> DONE on a terminal step when one_shot=1.
  - DONE -> IDLE on stop.
- Priority per edge: reset_n low > stop > load > start > step.
- Start applies the mode start value, clears the prescaler and clears wrap_count. Start values:
  - UP: 0, dir=0.
  - DOWN: limit, dir=1.
  - UPDOWN: 0, dir=0.
- start and load on the same edge: state goes to RUN and counter takes the clamped load_value; dir is set by mode.
- load: permitted in any state; clears the prescaler; does not change state.
- A step occurs when state=RUN, enable=1 and the prescaler tick fires.
- UP step:
  - counter<limit: counter+1.
  - counter>=limit: counter wraps to 0.
- DOWN step:
  - counter>0: counter-1.
  - counter==0: counter reloads limit.
- UPDOWN step: the counter moves in direction dir.
  - dir flips on the step that reaches limit while counting up.
  - dir flips on the step that reaches 0 while counting down.
  - Period is 2*limit steps.
- Terminal value (the step lands on it):
  - UP: limit.
  - DOWN: 0.
  - UPDOWN: 0 while counting down.
- On a terminal step, tc is high for the following cycle, coinciding with counter showing the terminal value. wrap_count increments and saturates at all-ones.
- In one-shot mode, the terminal step also enters DONE. The counter holds the terminal value and no further steps occur.
- An UP wrap from an out-of-range counter (counter>limit after limit was lowered) produces no tc.
- limit=0: the counter stays at 0. UP and DOWN produce tc on every step. UPDOWN produces tc on every step, and dir stays 1 after the first step.
- Arithmetic is modulo 2^WIDTH. There are no carries out of WIDTH, and limit=all-ones is legal.
- enable low freezes both prescaler and counter. tc is not generated while enable is low.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- start sampled at edge k: busy=1 after edge k. With prescale=0 and enable=1, the first step is visible after edge k+1.
- Step spacing is prescale+1 enabled cycles. The prescaler counts 0..prescale and ticks on the cycle where it equals prescale.
- Reset in mid-run: all state returns to reset values after that edge, regardless of other inputs.
- Changing prescale mid-run: if the prescaler is already above the new value, it wraps to 0 with a tick on the next enabled cycle.

## Structure
- Package prog_counter_pkg holds counter_mode_t, the FSM state typedef (ST_IDLE, ST_RUN, ST_DONE), and the MODE_* constants.
- Sub-module tick_prescaler(PRESCALE_W) has inputs clock, reset_n, clear, run and prescale, and output tick (combinational from its register). prog_counter instantiates it once.

## Test plan
- Free-run UP: WIDTH=8, limit=5, prescale=0, start. Required sequence is 1,2,3,4,5,0,1…, with tc high exactly when counter=5 and wrap_count incrementing each period.
- One-shot DOWN: limit=3, prescale=2, start. Counter steps 3→2→1→0, one step every 3 cycles. Then tc is high for one cycle, done=1, busy=0, and counter holds 0.
- UPDOWN: limit=2. Sequence 0,1,2,1,0,1…; dir toggles when the counter shows 2 and 0; tc is high only when counter shows 0 after counting down.
- Load clamp and priority: limit=10, load_value=200 with start on the same edge gives counter=10 and RUN. stop together with load gives IDLE with counter unchanged.
- Boundaries:
  - WIDTH=4, limit=15, UP: wraps 15→0.
  - wrap_count saturation with EVT_W=2: four terminal events give 3.
  - limit lowered to 2 while counter=7 in UP: next step gives 0 with no tc.
- Reset mid-run: reset_n low for one cycle during RUN with enable=1. All outputs are at reset values after that edge, and no steps occur until the next start.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// prog_counter_pkg: shared mode and FSM state definitions for prog_counter
package prog_counter_pkg;
  typedef enum logic [1:0] {
    MODE_UP     = 2'd0,
    MODE_DOWN   = 2'd1,
    MODE_UPDOWN = 2'd2
  } counter_mode_t;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;
endpackage

// File: rtl/prog_counter_if.sv
// prog_counter_if: control and status bundle between a timer client and prog_counter
interface prog_counter_if #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16,
  parameter int EVT_W      = 16
);
  logic                  start, stop, enable, one_shot, load;
  logic [1:0]            mode;
  logic [WIDTH-1:0]      limit, load_value, counter;
  logic [PRESCALE_W-1:0] prescale;
  logic                  dir, tc, done, busy;
  logic [EVT_W-1:0]      wrap_count;
  modport master (
    output start, stop, enable, one_shot, load, mode, limit, load_value, prescale,
    input  counter, dir, tc, done, busy, wrap_count
  );
  modport slave (
    input  start, stop, enable, one_shot, load, mode, limit, load_value, prescale,
    output counter, dir, tc, done, busy, wrap_count
  );
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides run cycles so tick fires once every prescale+1 of them
module tick_prescaler #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);
  logic [PRESCALE_W-1:0] cnt;
  // >= lets a lowered prescale wrap immediately instead of counting through the top
  assign tick = cnt >= prescale;
  always_ff @(posedge clock) begin
    if (!reset_n || clear) cnt <= '0;
    else if (run) cnt <= tick ? '0 : cnt + PRESCALE_W'(1);
  end
endmodule

// File: rtl/prog_counter.sv
// prog_counter: programmable up/down/triangle timer with prescaler, load and terminal events
module prog_counter
  import prog_counter_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int PRESCALE_W = 16,
  parameter int EVT_W      = 16
) (
  input logic          clock,
  input logic          reset_n,
  prog_counter_if.slave bus
);
  state_t           state;
  counter_mode_t    md;
  logic             tick, step, term, ndir, going_down, dir_q, tc_q;
  logic [WIDTH-1:0] cnt, lim, ld, nxt, up_nxt, dn_nxt;
  logic [EVT_W-1:0] wc;
  assign md   = bus.mode == 2'd3 ? MODE_UP : counter_mode_t'(bus.mode);
  assign lim  = bus.limit;
  assign ld   = bus.load_value > lim ? lim : bus.load_value;
  assign step = state == ST_RUN && bus.enable && tick;
  tick_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (!bus.stop && (bus.load || bus.start)),
    .run      (state == ST_RUN && bus.enable && !bus.stop),
    .prescale (bus.prescale),
    .tick     (tick)
  );
  // triangle mode turns around at the ends instead of wrapping
  always_comb begin
    up_nxt     = cnt < lim ? cnt + WIDTH'(1) : (md == MODE_UPDOWN ? lim : '0);
    dn_nxt     = cnt != '0 ? cnt - WIDTH'(1) : (md == MODE_UPDOWN ? '0 : lim);
    going_down = md == MODE_DOWN || (md == MODE_UPDOWN && dir_q);
    nxt        = going_down ? dn_nxt : up_nxt;
    ndir       = md == MODE_UPDOWN ? (dir_q ? (nxt != '0 || lim == '0) : nxt == lim) : md == MODE_DOWN;
    term       = md == MODE_UP   ? nxt == lim && cnt <= lim :
                 md == MODE_DOWN ? nxt == '0 : nxt == '0 && (dir_q || lim == '0);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      dir_q <= 1'b0;
      tc_q  <= 1'b0;
      wc    <= '0;
    end else if (bus.stop) begin
      state <= ST_IDLE;
      tc_q  <= 1'b0;
    end else if (bus.load || bus.start) begin
      tc_q <= 1'b0;
      cnt  <= bus.load ? ld : (md == MODE_DOWN ? lim : '0);
      if (bus.start) begin
        state <= ST_RUN;
        dir_q <= md == MODE_DOWN;
        wc    <= '0;
      end
    end else begin
      tc_q <= step && term;
      if (step) begin
        cnt   <= nxt;
        dir_q <= ndir;
        if (term) begin
          wc <= &wc ? wc : wc + EVT_W'(1);
          if (bus.one_shot) state <= ST_DONE;
        end
      end
    end
  end
  assign bus.counter    = cnt;
  assign bus.dir        = dir_q;
  assign bus.tc         = tc_q;
  assign bus.done       = state == ST_DONE;
  assign bus.busy       = state == ST_RUN;
  assign bus.wrap_count = wc;
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: directed and randomized checks of two prog_counter widths against a reference model
module tb_prog_counter;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;
  logic       clock = 1'b0, reset_n = 1'b0;
  logic       start = 1'b0, stop = 1'b0, enable = 1'b0, one_shot = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] limit = 8'd0, load_value = 8'd0;
  logic [3:0] prescale = 4'd0;
  int checks = 0, failures = 0;
  int m_cnt[2], m_dir[2], m_st[2], m_psc[2], m_tc[2], m_wc[2];
  int mx[2]  = '{255, 15};
  int emx[2] = '{3, 15};
  int tri_seq[4] = '{0, 1, 2, 1};
  always #5 clock = ~clock;
  prog_counter_if #(.WIDTH(8), .PRESCALE_W(4), .EVT_W(2)) ia();
  prog_counter_if #(.WIDTH(4), .PRESCALE_W(4), .EVT_W(4)) ib();
  assign ia.start = start;       assign ib.start = start;
  assign ia.stop = stop;         assign ib.stop = stop;
  assign ia.enable = enable;     assign ib.enable = enable;
  assign ia.one_shot = one_shot; assign ib.one_shot = one_shot;
  assign ia.load = load;         assign ib.load = load;
  assign ia.mode = mode;         assign ib.mode = mode;
  assign ia.prescale = prescale; assign ib.prescale = prescale;
  assign ia.limit = limit;       assign ib.limit = limit[3:0];
  assign ia.load_value = load_value;
  assign ib.load_value = load_value[3:0];
  prog_counter #(.WIDTH(8), .PRESCALE_W(4), .EVT_W(2)) dut_a (.clock(clock), .reset_n(reset_n), .bus(ia.slave));
  prog_counter #(.WIDTH(4), .PRESCALE_W(4), .EVT_W(4)) dut_b (.clock(clock), .reset_n(reset_n), .bus(ib.slave));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int lim, lv, m, c;
      bit hit;
      lim = int'(limit) & mx[k];
      lv  = int'(load_value) & mx[k];
      m   = mode == 2'd3 ? 0 : int'(mode);
      hit = 1'b0;
      m_tc[k] = 0;
      if (!reset_n) begin
        m_st[k] = M_IDLE; m_cnt[k] = 0; m_dir[k] = 0; m_wc[k] = 0; m_psc[k] = 0;
      end else if (stop) begin
        m_st[k] = M_IDLE;
      end else if (load || start) begin
        m_psc[k] = 0;
        m_cnt[k] = load ? (lv > lim ? lim : lv) : (m == 1 ? lim : 0);
        if (start) begin
          m_st[k] = M_RUN; m_dir[k] = int'(m == 1); m_wc[k] = 0;
        end
      end else if (m_st[k] == M_RUN && enable) begin
        if (m_psc[k] >= int'(prescale)) begin
          m_psc[k] = 0;
          c = m_cnt[k];
          if (m == 0) begin
            if (c < lim) begin c++; hit = c == lim; end
            else begin hit = c == lim && lim == 0; c = 0; end
            m_dir[k] = 0;
          end else if (m == 1) begin
            c = c == 0 ? lim : c - 1;
            hit = c == 0;
            m_dir[k] = 1;
          end else if (lim == 0) begin
            c = 0; m_dir[k] = 1; hit = 1'b1;
          end else if (m_dir[k] == 0) begin
            c = c < lim ? c + 1 : lim;
            if (c == lim) m_dir[k] = 1;
          end else begin
            c = c > 0 ? c - 1 : 0;
            if (c == 0) begin m_dir[k] = 0; hit = 1'b1; end
          end
          m_cnt[k] = c;
          if (hit) begin
            m_tc[k] = 1;
            m_wc[k] = m_wc[k] < emx[k] ? m_wc[k] + 1 : emx[k];
            if (one_shot) m_st[k] = M_DONE;
          end
        end else m_psc[k]++;
      end
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    model_edge();
    #1;
    chk("a.counter", int'(ia.counter), m_cnt[0]);
    chk("a.dir", int'(ia.dir), m_dir[0]);
    chk("a.tc", int'(ia.tc), m_tc[0]);
    chk("a.done", int'(ia.done), int'(m_st[0] == M_DONE));
    chk("a.busy", int'(ia.busy), int'(m_st[0] == M_RUN));
    chk("a.wrap_count", int'(ia.wrap_count), m_wc[0]);
    chk("b.counter", int'(ib.counter), m_cnt[1]);
    chk("b.dir", int'(ib.dir), m_dir[1]);
    chk("b.tc", int'(ib.tc), m_tc[1]);
    chk("b.done", int'(ib.done), int'(m_st[1] == M_DONE));
    chk("b.busy", int'(ib.busy), int'(m_st[1] == M_RUN));
    chk("b.wrap_count", int'(ib.wrap_count), m_wc[1]);
  endtask
  initial begin
    repeat (2) cyc();
    chk("rst.counter", int'(ia.counter), 0);
    chk("rst.busy", int'(ia.busy), 0);
    reset_n = 1'b1; enable = 1'b1;
    limit = 8'd5; start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      cyc();
      chk("up.seq", int'(ia.counter), i % 6);
      chk("up.tc", int'(ia.tc), int'(i % 6 == 5));
    end
    chk("up.wrap_sat", int'(ia.wrap_count), 3);
    chk("up.wrap_b", int'(ib.wrap_count), 4);
    mode = 2'd1; one_shot = 1'b1; limit = 8'd3; prescale = 4'd2;
    start = 1'b1; cyc(); start = 1'b0;
    chk("dn.start", int'(ia.counter), 3);
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk("dn.seq", int'(ia.counter), 3 - i / 3);
    end
    chk("dn.tc", int'(ia.tc), 1);
    chk("dn.done", int'(ia.done), 1);
    chk("dn.busy", int'(ia.busy), 0);
    repeat (4) cyc();
    chk("dn.hold", int'(ia.counter), 0);
    chk("dn.tc_once", int'(ia.tc), 0);
    stop = 1'b1; cyc(); stop = 1'b0;
    chk("dn.idle", int'(ia.done), 0);
    mode = 2'd2; one_shot = 1'b0; limit = 8'd2; prescale = 4'd0;
    start = 1'b1; cyc(); start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      chk("ud.seq", int'(ia.counter), tri_seq[i % 4]);
      chk("ud.tc", int'(ia.tc), int'(i % 4 == 0));
      chk("ud.dir", int'(ia.dir), int'(i % 4 == 2 || i % 4 == 3));
    end
    mode = 2'd0; limit = 8'd10; load_value = 8'd200; load = 1'b1; start = 1'b1;
    cyc(); load = 1'b0; start = 1'b0;
    chk("ld.clamp", int'(ia.counter), 10);
    chk("ld.busy", int'(ia.busy), 1);
    stop = 1'b1; load = 1'b1; load_value = 8'd4; cyc(); stop = 1'b0; load = 1'b0;
    chk("ld.stop_cnt", int'(ia.counter), 10);
    chk("ld.stop_idle", int'(ia.busy), 0);
    start = 1'b1; cyc(); start = 1'b0;
    load = 1'b1; load_value = 8'd7; cyc(); load = 1'b0;
    chk("lo.loaded", int'(ia.counter), 7);
    limit = 8'd2; cyc();
    chk("lo.wrap", int'(ia.counter), 0);
    chk("lo.no_tc", int'(ia.tc), 0);
    limit = 8'd255; load_value = 8'd254; load = 1'b1; start = 1'b1;
    cyc(); load = 1'b0; start = 1'b0;
    cyc();
    chk("ff.a_top", int'(ia.counter), 255);
    chk("ff.b_top", int'(ib.counter), 15);
    chk("ff.b_tc", int'(ib.tc), 1);
    cyc();
    chk("ff.a_wrap", int'(ia.counter), 0);
    chk("ff.b_wrap", int'(ib.counter), 0);
    repeat (3) cyc();
    reset_n = 1'b0; start = 1'b1; cyc(); reset_n = 1'b1; start = 1'b0;
    chk("rr.counter", int'(ia.counter), 0);
    chk("rr.busy", int'(ia.busy), 0);
    chk("rr.wrap", int'(ia.wrap_count), 0);
    repeat (3) cyc();
    chk("rr.hold", int'(ia.counter), 0);
    chk("rr.idle", int'(ia.busy), 0);
    for (int n = 0; n < 3000; n++) begin
      reset_n    = $urandom_range(0, 199) != 0;
      start      = $urandom_range(0, 29) == 0;
      stop       = $urandom_range(0, 59) == 0;
      load       = $urandom_range(0, 39) == 0;
      enable     = $urandom_range(0, 4) != 0;
      load_value = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) one_shot = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) prescale = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0)
        limit = $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      cyc();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
